// File: rtl/dps_enc_seq_if.sv
// Handshake bundle for dps_enc_seq: input side (in_valid/in_ready/datain) and result side (out_valid/out_ready/codeout/code_err).
// Latency: none, wires only.
// Backpressure: carried by in_ready toward the producer and out_ready toward the encoder.
interface dps_enc_seq_if #(
    parameter int CW = 8
);
    function automatic int fib(input int n);
        int a;
        int b;
        int t;
        a = 1;
        b = 1;
        for (int i = 3; i <= n; i++) begin
            t = a + b;
            a = b;
            b = t;
        end
        return b;
    endfunction

    localparam int MAXVAL = fib(CW + 2) - 1;
    localparam int DW     = $clog2(MAXVAL + 1);

    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] datain;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] codeout;
    logic          code_err;
    logic          busy;

    modport master (
        output in_valid, datain, out_ready,
        input  in_ready, out_valid, codeout, code_err, busy
    );

    modport slave (
        input  in_valid, datain, out_ready,
        output in_ready, out_valid, codeout, code_err, busy
    );
endinterface

// File: rtl/dps_enc_seq.sv
// Sequential Fibonacci (Zeckendorf) encoder, one codeword bit per cycle MSB first; DPS_ENC_RANGE_CHK_EN adds an out-of-range flag.
// Latency: CW+1 edges from the transfer edge to out_valid, or 1 edge for a flagged out-of-range input.
// Backpressure: accepts only in IDLE; the result is held in DONE until out_ready.
module dps_enc_seq #(
    parameter int CW = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    dps_enc_seq_if.slave bus
);
    function automatic int fib(input int n);
        int a;
        int b;
        int t;
        a = 1;
        b = 1;
        for (int i = 3; i <= n; i++) begin
            t = a + b;
            a = b;
            b = t;
        end
        return b;
    endfunction

    localparam int MAXVAL = fib(CW + 2) - 1;
    localparam int DW     = $clog2(MAXVAL + 1);
    localparam int KW     = $clog2(CW);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ENC  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [DW-1:0] rem;
    logic [CW-1:0] code;
    logic [KW-1:0] k;
    logic          xfer;
    logic          oor;
    logic [DW-1:0] w_cur;
    logic          bit_set;

    // Weight of code bit g is fib(g+2); fib(CW+1) <= MAXVAL so every weight fits DW bits.
    logic [DW-1:0] wtab [CW];
    for (genvar g = 0; g < CW; g++) begin : g_wtab
        assign wtab[g] = DW'(fib(g + 2));
    end

    assign xfer    = bus.in_valid & bus.in_ready;
    assign w_cur   = wtab[k];
    assign bit_set = (rem >= w_cur);

`ifdef DPS_ENC_RANGE_CHK_EN
    logic err;

    assign oor          = (bus.datain > DW'(MAXVAL));
    assign bus.code_err = err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else if (xfer) begin
            err <= oor;
        end else if (state == DONE && bus.out_ready) begin
            err <= 1'b0;
        end
    end
`else
    assign oor          = 1'b0;
    assign bus.code_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (xfer) state_nxt = oor ? DONE : ENC;
            ENC:     if (k == '0) state_nxt = DONE;
            DONE:    if (bus.out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.busy      = 1'b1;
        case (state)
            IDLE: begin
                bus.in_ready = 1'b1;
                bus.busy     = 1'b0;
            end
            DONE:    bus.out_valid = 1'b1;
            default: ;
        endcase
    end

    // Greedy subtraction is only taken when rem >= weight, so rem cannot wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem  <= '0;
            code <= '0;
            k    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (xfer) begin
                        rem  <= bus.datain;
                        code <= '0;
                        k    <= KW'(CW - 1);
                    end
                end
                ENC: begin
                    code <= {code[CW-2:0], bit_set};
                    if (bit_set) rem <= rem - w_cur;
                    if (k != '0) k <= k - 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.codeout = code;
endmodule
